// File: rtl/burst_line_adapter.sv
// Cacheline-to-burst adapter: one 256-bit line request becomes a held 4-beat
// 64-bit burst on pmem; read beats are assembled into a registered line.
module burst_line_adapter #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               line_address,
  input  logic                      line_read,
  input  logic                      line_write,
  input  logic [BEAT_W*BEATS-1:0]   line_wdata,
  output logic [BEAT_W*BEATS-1:0]   line_rdata,
  output logic                      line_resp,
  output logic [31:0]               pmem_address,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic [BEAT_W-1:0]         pmem_wdata,
  input  logic [BEAT_W-1:0]         pmem_rdata,
  input  logic                      pmem_resp
);

  localparam int OFF = $clog2(BEAT_W*BEATS/8);
  localparam int CW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS-1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                        state;
  logic [CW-1:0]                 cnt;
  logic [CW-1:0]                 cnt_nxt;
  logic [BEATS-1:0][BEAT_W-1:0]  wbuf;
  logic [BEATS-1:0][BEAT_W-1:0]  rbuf;
  logic                          unused_offset;

  assign cnt_nxt       = cnt + 1'b1;
  assign line_rdata    = rbuf;
  assign unused_offset = ^line_address[OFF-1:0];

  // All outputs are registered; pmem_resp outside READ/WRITE falls through untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      wbuf         <= '0;
      rbuf         <= '0;
      line_resp    <= 1'b0;
      pmem_address <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_wdata   <= '0;
    end else begin
      line_resp <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          // Write wins if both requests are raised together.
          if (line_write) begin
            state        <= WRITE;
            pmem_write   <= 1'b1;
            pmem_address <= {line_address[31:OFF], {OFF{1'b0}}};
            wbuf         <= line_wdata;
            pmem_wdata   <= line_wdata[BEAT_W-1:0];
          end else if (line_read) begin
            state        <= READ;
            pmem_read    <= 1'b1;
            pmem_address <= {line_address[31:OFF], {OFF{1'b0}}};
          end
        end
        READ: begin
          if (pmem_resp) begin
            rbuf[cnt] <= pmem_rdata;
            cnt       <= cnt_nxt;
            if (cnt == LAST) begin
              cnt       <= '0;
              state     <= DONE;
              pmem_read <= 1'b0;
              line_resp <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (pmem_resp) begin
            cnt <= cnt_nxt;
            if (cnt == LAST) begin
              cnt        <= '0;
              state      <= DONE;
              pmem_write <= 1'b0;
              line_resp  <= 1'b1;
            end else begin
              pmem_wdata <= wbuf[cnt_nxt];
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_line_adapter.sv
// Bench for burst_line_adapter: table of directed bursts, randomized bursts with
// random pmem gaps, and hand-written reset/spurious-response sequences.
module tb_burst_line_adapter;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;
  localparam int LW     = BEAT_W*BEATS;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       line_address;
  logic              line_read, line_write;
  logic [LW-1:0]     line_wdata, line_rdata;
  logic              line_resp;
  logic [31:0]       pmem_address;
  logic              pmem_read, pmem_write;
  logic [BEAT_W-1:0] pmem_wdata, pmem_rdata;
  logic              pmem_resp;

  int n_cmp = 0;
  int n_bad = 0;
  logic [LW-1:0] model_rdata;

  burst_line_adapter #(.BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst),
    .line_address(line_address), .line_read(line_read), .line_write(line_write),
    .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            rd;
    bit            wr;
    logic [31:0]   addr;
    logic [LW-1:0] wd;
    logic [LW-1:0] rl;
    logic [31:0]   pat;   // per-cycle pmem_resp pattern, bit i = burst cycle i+1
    int            plen;  // 0 selects random gaps
    int            gap;   // percent chance of a stalled cycle
  } vec_t;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd256();
    logic [LW-1:0] r;
    for (int i = 0; i < LW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_resp"}, line_resp, 1'b0);
    check({name, "_rd"}, pmem_read, 1'b0);
    check({name, "_wr"}, pmem_write, 1'b0);
    check({name, "_rdata"}, line_rdata, model_rdata);
  endtask

  // One line transaction against an ideal memory: expectations come from the
  // number of beats accepted so far, not from any view of the DUT's state.
  task automatic txn(input vec_t v);
    logic [31:0] al;
    bit          is_wr, resp;
    int          beats, cyc;
    al    = {v.addr[31:5], 5'b0};
    is_wr = v.wr;
    line_read    = v.rd;
    line_write   = v.wr;
    line_address = v.addr;
    line_wdata   = v.wd;
    pmem_resp    = 1'($urandom_range(0, 1));
    pmem_rdata   = {$urandom, $urandom};
    tick();
    beats = 0;
    cyc   = 0;
    while (beats < BEATS && cyc < 200) begin
      check("burst_rd", pmem_read, !is_wr);
      check("burst_wr", pmem_write, is_wr);
      check("burst_addr", pmem_address, al);
      check("burst_early_resp", line_resp, 1'b0);
      if (is_wr) check("burst_wdata", pmem_wdata, v.wd[beats*BEAT_W +: BEAT_W]);
      if (v.plen > 0) resp = (cyc < v.plen) ? v.pat[cyc] : 1'b1;
      else            resp = ($urandom_range(0, 99) >= v.gap);
      pmem_resp  = resp;
      pmem_rdata = resp ? v.rl[beats*BEAT_W +: BEAT_W] : {$urandom, $urandom};
      line_address = $urandom;
      line_wdata   = rnd256();
      tick();
      if (resp) beats++;
      cyc++;
    end
    check("burst_timeout", beats, BEATS);
    if (!is_wr) model_rdata = v.rl;
    check("done_resp", line_resp, 1'b1);
    check("done_rd", pmem_read, 1'b0);
    check("done_wr", pmem_write, 1'b0);
    check("done_rdata", line_rdata, model_rdata);
    line_read  = 1'b0;
    line_write = 1'b0;
    pmem_resp  = 1'($urandom_range(0, 1));
    tick();
    check_quiet("after_done");
    pmem_resp = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    line_read = 1'b0;
    line_write = 1'b0;
    pmem_resp = 1'b0;
    model_rdata = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      check("rst_resp", line_resp, 1'b0);
      check("rst_rd", pmem_read, 1'b0);
      check("rst_wr", pmem_write, 1'b0);
      check("rst_addr", pmem_address, 32'h0);
      check("rst_wdata", pmem_wdata, 64'h0);
      check("rst_rdata", line_rdata, '0);
    end
    rst = 1'b0;
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    logic [BEAT_W-1:0] a, b, c, d;
    rst = 1'b1;
    line_address = '0; line_read = 1'b0; line_write = 1'b0;
    line_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    model_rdata = '0;

    a = {16{4'hA}}; b = {16{4'hB}}; c = {16{4'hC}}; d = {16{4'hD}};
    tbl[0] = '{1'b1, 1'b0, 32'h0000_1234, '0,
               {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 32'hF, 4, 0};
    tbl[1] = '{1'b0, 1'b1, 32'hABCD_EF5F, {d, c, b, a}, '0, 32'h59, 7, 0};
    tbl[2] = '{1'b1, 1'b0, 32'h8000_0040, '0, rnd256(), 32'h0, 0, 30};
    tbl[3] = '{1'b0, 1'b1, 32'h0000_0000, rnd256(), rnd256(), 32'h0, 0, 50};
    tbl[4] = '{1'b1, 1'b0, 32'h7FFF_FFE1, '0, rnd256(), 32'h0, 0, 20};
    tbl[5] = '{1'b1, 1'b1, 32'hFFFF_FFFF, rnd256(), rnd256(), 32'hF, 4, 0};

    do_reset(2);
    foreach (tbl[i]) txn(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      rv.wr   = 1'($urandom_range(0, 1));
      rv.rd   = rv.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.addr = $urandom;
      rv.wd   = rnd256();
      rv.rl   = rnd256();
      rv.pat  = '0;
      rv.plen = 0;
      rv.gap  = $urandom_range(0, 70);
      txn(rv);
    end

    // Abandon a read after two beats by holding reset for two cycles.
    line_read = 1'b1;
    line_address = 32'h0000_2000;
    tick();
    for (int i = 0; i < 2; i++) begin
      pmem_resp  = 1'b1;
      pmem_rdata = {$urandom, $urandom};
      tick();
    end
    do_reset(2);
    tick();
    check_quiet("post_rst");

    // Spurious responses while idle must not advance anything.
    for (int i = 0; i < 6; i++) begin
      pmem_resp  = 1'($urandom_range(0, 1));
      pmem_rdata = {$urandom, $urandom};
      tick();
      check_quiet("idle_spur");
    end
    pmem_resp = 1'b0;
    tbl[0].rl = rnd256();
    txn(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/burst_line_adapter.md
# burst_line_adapter

Converts one 256-bit cacheline read or write into a 4-beat, 64-bit burst on the physical-memory port. It sits directly downstream of the instruction/data cache arbiter and drives the 64-bit pmem bus (pmem_read/pmem_write/pmem_address/pmem_wdata/pmem_rdata/pmem_resp). Upstream sees a single line-wide request/response handshake; downstream sees a held request with per-beat pmem_resp.

## Interface
- BEAT_W, 64, width of one memory beat in bits
- BEATS, 4, beats per line; line width = BEAT_W*BEATS = 256; line offset bits = log2(BEAT_W*BEATS/8) = 5
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; **one clock; reset is synchronous and active-high**
- line_address  in  32  line request address; low 5 bits ignored
- line_read  in  1  line read request, held until line_resp
- line_write  in  1  line write request, held until line_resp
- line_wdata  in  256  write line; beat k = bits [64k+63:64k]
- line_rdata  out  256  assembled read line
- line_resp  out  1  one-cycle completion pulse
- pmem_address  out  32  line-aligned burst address
- pmem_read  out  1  burst read request, held for whole burst
- pmem_write  out  1  burst write request, held for whole burst
- pmem_wdata  out  64  current write beat
- pmem_rdata  in  64  current read beat
- pmem_resp  in  1  one beat transferred this cycle

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: if line_write → latch {line_address[31:5],5'b0} and line_wdata, beat counter=0, go WRITE; else if line_read → latch address, counter=0, go READ. Both asserted: write wins (illegal upstream, but defined).
- READ: pmem_read=1. On each cycle with pmem_resp=1, store pmem_rdata into line buffer slice [counter], counter++. On beat BEATS-1 → DONE.
- WRITE: pmem_write=1, pmem_wdata = latched slice [counter]. Each pmem_resp advances counter; beat BEATS-1 → DONE.
- DONE: line_resp=1 for exactly one cycle, pmem_read=pmem_write=0, → IDLE.
- Gaps allowed: pmem_resp low mid-burst holds state, counter, and pmem_wdata.
- pmem_resp in IDLE or DONE is ignored.
- pmem_address constant for the whole burst; beat ordering is implicit (memory increments internally).
- line_rdata is a register: updated only by read beats, stable from DONE until the next read's first beat; writes never change it.
- Upstream inputs are sampled only in IDLE; changes to them during a burst have no effect.
- Counter is log2(BEATS) bits; never wraps inside a burst (exit at BEATS-1).

## Timing
- Reset (synchronous, rst high at edge): state=IDLE, counter=0, line_rdata=0, latched address/wdata=0; outputs line_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
- Reset mid-burst: at the next edge return to IDLE, all outputs low next cycle, burst abandoned, no line_resp; pmem model is reset concurrently.
- Cycle 0 = first IDLE cycle with request high. pmem_read/pmem_write high from cycle 1 through cycle of last beat t; line_resp high at t+1, pmem request low at t+1.
- Minimum latency (resp on every cycle): beats at cycles 1-4, line_resp at cycle 5; IDLE at cycle 6.
- line_rdata complete and valid in the line_resp cycle.
- Upstream must drop its request on the edge ending the line_resp cycle; a request still high in IDLE at cycle t+2 starts a new burst.
- Outputs are functions of registered state only (no input→output combinational path).

## Test plan
- Reset: hold rst 2 cycles mid-burst → all outputs 0 next cycle, no line_resp, line_rdata=0.
- Back-to-back read, address 0x0000_1234, memory beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on cycles 1-4 → pmem_address=0x0000_1220, line_resp at cycle 5, line_rdata = {0x44..44,0x33..33,0x22..22,0x11..11}.
- Write with gaps, line_wdata beats A,B,C,D, pmem_resp pattern 1,0,0,1,1,0,1 → pmem_wdata A,B,B,B,C,D,D, line_resp 1 cycle after last resp, pmem_write low then.
- Read then write then read: line_rdata unchanged across the write, updated only after second read.
- line_read and line_write both high → WRITE burst performed, pmem_read never asserted.
- Spurious pmem_resp in IDLE and DONE → no state change, counter stays 0, no line_resp.
